// File: rtl/wrr_arbiter_if.sv
// Requester/arbiter bundle for wrr_arbiter. The master drives requests,
// locks and weights. The slave (the arbiter) returns the registered grant.
interface wrr_arbiter_if #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned WEIGHT_W  = 4,
   parameter int unsigned ID_W      = $clog2(NUM_PORTS)
);
   logic [NUM_PORTS-1:0]          req_i;
   logic [NUM_PORTS-1:0]          lock_i;
   logic [NUM_PORTS*WEIGHT_W-1:0] weight_i;
   logic [NUM_PORTS-1:0]          gnt_o;
   logic [ID_W-1:0]               gnt_id_o;
   logic                          gnt_vld_o;
   logic [WEIGHT_W-1:0]           credit_o;

   modport master (
      output req_i, lock_i, weight_i,
      input  gnt_o, gnt_id_o, gnt_vld_o, credit_o
   );

   modport slave (
      input  req_i, lock_i, weight_i,
      output gnt_o, gnt_id_o, gnt_vld_o, credit_o
   );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with packet lock.
// Each winner gets a tenure of up to its weight in beats. An asserted lock
// extends the tenure past the weight. The next winner is chosen in the same
// cycle that a tenure ends, so no idle cycle separates tenures.
module wrr_arbiter #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned WEIGHT_W  = 4,
   parameter int unsigned ID_W      = $clog2(NUM_PORTS)
) (
   input  logic         clk,
   input  logic         reset_n,
   wrr_arbiter_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [WEIGHT_W-1:0] credit_q, credit_d;

   logic [WEIGHT_W-1:0] weight_a [NUM_PORTS];
   logic [ID_W-1:0]     scan_base;
   logic [ID_W-1:0]     win_id;
   logic                win_vld;
   logic [WEIGHT_W-1:0] win_credit;
   logic                beat;
   logic                tenure_end;

   // Unpack the flat weight bus into one entry per port
   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         weight_a[p] = bus.weight_i[p*WEIGHT_W +: WEIGHT_W];
      end
   end

   // Round-robin search: start after the base port, wrap, and take the first requester
   always_comb begin
      int unsigned idx;
      // A tenure ends only in GRANT, and it moves ptr to the owner, so the
      // owner is the base here. This places the owner last in the scan.
      scan_base = (state_q == GRANT) ? owner_q : ptr_q;
      win_vld   = 1'b0;
      win_id    = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         idx = 32'(scan_base) + i;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end
         if (!win_vld && bus.req_i[ID_W'(idx)]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
      win_credit = (weight_a[win_id] == '0) ? WEIGHT_W'(1) : weight_a[win_id];
   end

   // State register: FSM state, tenure owner, remaining credit, last-served pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         credit_q <= '0;
         ptr_q    <= ID_W'(NUM_PORTS - 1);
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
         ptr_q    <= ptr_d;
      end
   end

   // Next-state logic: grant from idle, count beats, and hand over at tenure end
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      credit_d   = credit_q;
      ptr_d      = ptr_q;
      beat       = bus.req_i[owner_q];
      tenure_end = !beat || ((credit_q <= WEIGHT_W'(1)) && !bus.lock_i[owner_q]);
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d  = GRANT;
               owner_d  = win_id;
               credit_d = win_credit;
            end
         end
         GRANT: begin
            if (tenure_end) begin
               ptr_d = owner_q;
               if (win_vld) begin
                  owner_d  = win_id;
                  credit_d = win_credit;
               end else begin
                  state_d  = IDLE;
                  owner_d  = '0;
                  credit_d = '0;
               end
            end else if (credit_q != '0) begin
               credit_d = credit_q - WEIGHT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: one-hot grant and its index/credit, all zero while idle
   always_comb begin
      bus.gnt_o = '0;
      if (state_q == GRANT) begin
         bus.gnt_o[owner_q] = 1'b1;
      end
      bus.gnt_id_o  = owner_q;
      bus.gnt_vld_o = (state_q == GRANT);
      bus.credit_o  = credit_q;
   end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Testbench for wrr_arbiter. It runs directed scenarios with literal
// expectations and then randomized traffic. An integer-level model is
// compared with the DUT on every falling clock edge.
module tb_wrr_arbiter;
   localparam int N  = 4;
   localparam int WW = 4;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   wrr_arbiter_if #(.NUM_PORTS(N), .WEIGHT_W(WW)) bus ();

   wrr_arbiter #(.NUM_PORTS(N), .WEIGHT_W(WW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner == -1 means idle
   int m_owner = -1;
   int m_credit = 0;
   int m_ptr = N - 1;
   int n_owner, n_credit, n_ptr;

   function automatic int eff_weight(input logic [N*WW-1:0] w, input int p);
      int x;
      x = int'((w >> (WW * p)) & ((1 << WW) - 1));
      return (x == 0) ? 1 : x;
   endfunction

   function automatic int pick(input int base, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   function automatic void model_step(input int owner, input int credit, input int ptr,
                                      input logic [N-1:0] r, input logic [N-1:0] lk,
                                      input logic [N*WW-1:0] w,
                                      output int o_owner, output int o_credit, output int o_ptr);
      bit done;
      int win;
      o_owner  = owner;
      o_credit = credit;
      o_ptr    = ptr;
      if (owner < 0) begin
         done = 1'b1;
      end else begin
         done = !r[owner] || (credit <= 1 && !lk[owner]);
         if (!done && credit > 0) o_credit = credit - 1;
         if (done) o_ptr = owner;
      end
      if (done) begin
         win      = pick(o_ptr, r);
         o_owner  = win;
         o_credit = (win < 0) ? 0 : eff_weight(w, win);
      end
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_owner  <= -1;
         m_credit <= 0;
         m_ptr    <= N - 1;
      end else begin
         model_step(m_owner, m_credit, m_ptr, bus.req_i, bus.lock_i, bus.weight_i,
                    n_owner, n_credit, n_ptr);
         m_owner  <= n_owner;
         m_credit <= n_credit;
         m_ptr    <= n_ptr;
      end
   end

   // Compare the DUT with the model on every falling edge
   always @(negedge clk) begin
      chk("cmp_gnt_o", int'(bus.gnt_o), (m_owner < 0) ? 0 : (1 << m_owner));
      chk("cmp_gnt_id_o", int'(bus.gnt_id_o), (m_owner < 0) ? 0 : m_owner);
      chk("cmp_gnt_vld_o", int'(bus.gnt_vld_o), (m_owner >= 0) ? 1 : 0);
      chk("cmp_credit_o", int'(bus.credit_o), m_credit);
      chk("cmp_onehot0", int'($onehot0(bus.gnt_o)), 1);
   end

   // ---------------- directed helpers ----------------
   task automatic expect_cyc(input string nm, input int id, input int cr);
      @(negedge clk);
      chk({nm, "_id"}, int'(bus.gnt_id_o), id);
      chk({nm, "_credit"}, int'(bus.credit_o), cr);
      chk({nm, "_vld"}, int'(bus.gnt_vld_o), 1);
   endtask

   task automatic expect_idle(input string nm);
      @(negedge clk);
      chk({nm, "_gnt"}, int'(bus.gnt_o), 0);
      chk({nm, "_id"}, int'(bus.gnt_id_o), 0);
      chk({nm, "_vld"}, int'(bus.gnt_vld_o), 0);
      chk({nm, "_credit"}, int'(bus.credit_o), 0);
   endtask

   task automatic reset_pulse(input logic [N-1:0] r, input logic [N*WW-1:0] w);
      @(negedge clk);
      #1;
      reset_n      = 1'b0;
      bus.req_i    = r;
      bus.lock_i   = '0;
      bus.weight_i = w;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   int t2_id [10];
   int t2_cr [10];
   int dens;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      t2_id = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
      t2_cr = '{3, 2, 1, 1, 2, 1, 1, 3, 2, 1};
      reset_n      = 1'b1;
      bus.req_i    = '0;
      bus.lock_i   = '0;
      bus.weight_i = '0;
      #2 reset_n = 1'b0;

      // Reset state
      expect_idle("reset");

      // Weights all 1, all request: rotate 0,1,2,3,0,1 with no bubbles
      reset_pulse(4'b1111, 16'h1111);
      for (int i = 0; i < 6; i++) expect_cyc("rr_w1", i % N, 1);

      // Weights p0=3,p1=1,p2=2,p3=0
      reset_pulse(4'b1111, 16'h0213);
      for (int i = 0; i < 10; i++) expect_cyc("wrr", t2_id[i], t2_cr[i]);

      // Port 1 alone, weight 2: re-granted to itself, then idle after the drop
      reset_pulse(4'b0010, 16'h0020);
      for (int i = 0; i < 5; i++) begin
         expect_cyc("solo", 1, (i % 2 == 0) ? 2 : 1);
         chk("solo_gnt", int'(bus.gnt_o), 2);
      end
      #1 bus.req_i = 4'b0000;
      expect_idle("solo_drop");

      // Lock on port 2 (weight 1) holds past the weight while ports 0 and 3 wait
      #1;
      bus.req_i    = 4'b1101;
      bus.lock_i   = 4'b0100;
      bus.weight_i = 16'h2111;
      expect_cyc("lock", 2, 1);
      for (int i = 0; i < 5; i++) expect_cyc("lock_hold", 2, 0);
      #1 bus.lock_i = 4'b0000;
      expect_cyc("lock_release", 3, 2);

      // Owner 0 drops its request mid-tenure; it is served again only after 1,2,3
      reset_pulse(4'b0011, 16'h1113);
      expect_cyc("drop0", 0, 3);
      expect_cyc("drop0", 0, 2);
      #1 bus.req_i = 4'b1110;
      expect_cyc("drop_to1", 1, 1);
      #1 bus.req_i = 4'b1111;
      expect_cyc("after1", 2, 1);
      expect_cyc("after2", 3, 1);
      expect_cyc("after3", 0, 3);

      // Reset asserted mid-tenure clears outputs without waiting for a clock edge
      reset_pulse(4'b0100, 16'h0300);
      expect_cyc("arst_pre", 2, 3);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_gnt", int'(bus.gnt_o), 0);
      chk("arst_id", int'(bus.gnt_id_o), 0);
      chk("arst_vld", int'(bus.gnt_vld_o), 0);
      chk("arst_credit", int'(bus.credit_o), 0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      expect_cyc("arst_post", 2, 3);

      // Randomized traffic, checked by the model on every cycle
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         #1;
         dens = (c / 400) % 4;
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(249) == 0) reset_n = 1'b0;
         for (int p = 0; p < N; p++) begin
            bus.req_i[p]  = ($urandom_range(3) <= dens);
            bus.lock_i[p] = bus.lock_i[p] ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
         end
         if ($urandom_range(9) == 0) bus.weight_i = 16'($urandom);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
